// File: rtl/sc_ulpi_pkg.sv
// Shared types and constants for the ULPI receive interface: FSM states,
// RX CMD byte layout and rxEvent encodings.
package sc_ulpi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TURN_IN  = 2'd1,
    RECV     = 2'd2,
    TURN_OUT = 2'd3
  } rxIfState_e;

  // rxEvent field encodings of an RX CMD byte
  localparam logic [1:0] RxActive       = 2'b01;
  localparam logic [1:0] HostDisconnect = 2'b10;
  localparam logic [1:0] RxError        = 2'b11;

  localparam logic [10:0] RX_LEN_SAT   = 11'h7FF;
  localparam logic [15:0] STAT_CNT_MAX = 16'hFFFF;

  // RX CMD byte as sent by the PHY, MSB first
  typedef struct packed {
    logic       alt_int;
    logic       id_gnd;
    logic [1:0] rx_event;
    logic [1:0] vbus_state;
    logic [1:0] line_state;
  } rxCmd_s;

  function automatic logic [1:0] rx_event_of(input logic [7:0] b);
    rxCmd_s c;
    c = rxCmd_s'(b);
    return c.rx_event;
  endfunction

endpackage

// File: rtl/sc_ulpi_rxstat.sv
// Saturating packet / error counters for the ULPI receive interface.
// Only built when SC_ULPI_RXIF_STAT_EN is defined.
`ifdef SC_ULPI_RXIF_STAT_EN
module sc_ulpi_rxstat
  import sc_ulpi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pkt_evt,
  input  logic        i_err_evt,
  output logic [15:0] o_pkt_cnt,
  output logic [15:0] o_err_cnt
);

  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  // count end and error strobes, holding at full scale
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (i_pkt_evt && (r_pkt_cnt != STAT_CNT_MAX)) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (i_err_evt && (r_err_cnt != STAT_CNT_MAX)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign o_pkt_cnt = r_pkt_cnt;
  assign o_err_cnt = r_err_cnt;

endmodule
`endif

// File: rtl/sc_ulpi_rxif.sv
// ULPI receive interface: registers the raw pads, tracks bus turnaround,
// splits PHY bytes into RX CMDs and USB data, and frames packets.
// Optional statistics counters are built under SC_ULPI_RXIF_STAT_EN.
//
// state    | meaning
// IDLE     | link owns the bus, transmit driver enabled
// TURN_IN  | turnaround cycle after DIR rose, byte ignored
// RECV     | PHY drives bus, each byte is RX CMD or data
// TURN_OUT | turnaround cycle after DIR fell, byte ignored
//
// The registered state is the state that the most recent stage-1 sample
// belongs to; w_state_nxt is the state of the sample being processed now.
module sc_ulpi_rxif
  import sc_ulpi_pkg::*;
#(
  parameter int MAX_PKT_LEN = 1027
) (
  input  logic        ULPICLK,
  input  logic        ULPIRST,
  input  logic        ULPI_DIR,
  input  logic        ULPI_NXT,
  input  logic [7:0]  ULPI_DATA_I,
  output logic        RXD_CMD_VALID,
  output logic        RXD_DATA_VALID,
  output logic [7:0]  ULPI_DATA,
  output logic        RX_ACTIVE,
  output logic        RX_SOP,
  output logic        RX_EOP,
  output logic        RX_ERR,
  output logic [10:0] RX_LEN,
  output logic [15:0] STAT_PKT_CNT,
  output logic [15:0] STAT_ERR_CNT,
  output logic        LINK_OWNS_BUS
);

  localparam logic [11:0] MAX_LEN = 12'(MAX_PKT_LEN);

  logic        r_dir;
  logic        r_nxt;
  logic [7:0]  r_data;

  rxIfState_e  r_state;
  rxIfState_e  w_state_nxt;

  logic        r_cmd_valid;
  logic        r_data_valid;
  logic [7:0]  r_ulpi_data;
  logic        r_rx_active;
  logic        r_sop;
  logic        r_eop;
  logic        r_err;
  logic [10:0] r_len;
  logic        r_link_owns;
  logic        r_sop_pend;
  logic        r_ovf_seen;

  logic        w_cmd_valid;
  logic        w_data_valid;
  logic [7:0]  w_data;
  logic        w_active;
  logic        w_sop;
  logic        w_eop;
  logic        w_err;
  logic [10:0] w_len;
  logic        w_sop_pend;
  logic        w_ovf_seen;

  logic [1:0]  w_rx_event;
  logic [11:0] w_len_inc;
  logic        w_over;
  logic [10:0] w_len_sat;

  assign w_rx_event = rx_event_of(r_data);
  assign w_len_inc  = {1'b0, r_len} + 12'd1;
  assign w_over     = (w_len_inc > MAX_LEN);
  assign w_len_sat  = (r_len == RX_LEN_SAT) ? r_len : (r_len + 11'd1);

  // stage 1: single register on every pad
  always_ff @(posedge ULPICLK or posedge ULPIRST) begin
    if (ULPIRST) begin
      r_dir  <= 1'b0;
      r_nxt  <= 1'b0;
      r_data <= 8'h00;
    end else begin
      r_dir  <= ULPI_DIR;
      r_nxt  <= ULPI_NXT;
      r_data <= ULPI_DATA_I;
    end
  end

  // FSM state register
  always_ff @(posedge ULPICLK or posedge ULPIRST) begin
    if (ULPIRST) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // next state and next values of the stage-2 outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_valid  = 1'b0;
    w_data_valid = 1'b0;
    w_data       = r_ulpi_data;
    w_active     = r_rx_active;
    w_sop        = 1'b0;
    w_eop        = 1'b0;
    w_err        = 1'b0;
    w_len        = r_len;
    w_sop_pend   = r_sop_pend;
    w_ovf_seen   = r_ovf_seen;

    case (r_state)
      IDLE:          w_state_nxt = r_dir ? TURN_IN : IDLE;
      TURN_IN, RECV: w_state_nxt = r_dir ? RECV : TURN_OUT;
      TURN_OUT:      w_state_nxt = r_dir ? TURN_IN : IDLE;
      default:       w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      TURN_IN: begin
        // NXT during the turnaround is the PHY's RxActive shortcut
        if (r_nxt) begin
          w_active   = 1'b1;
          w_len      = '0;
          w_sop_pend = 1'b1;
          w_ovf_seen = 1'b0;
        end
      end
      RECV: begin
        if (!r_nxt) begin
          w_cmd_valid = 1'b1;
          w_data      = r_data;
          if (w_rx_event == RxActive) begin
            if (!r_rx_active) begin
              w_active   = 1'b1;
              w_len      = '0;
              w_sop_pend = 1'b1;
              w_ovf_seen = 1'b0;
            end
          end else if (w_rx_event == RxError) begin
            if (r_rx_active) w_err = 1'b1;
          end else if (r_rx_active) begin
            w_active   = 1'b0;
            w_eop      = 1'b1;
            w_sop_pend = 1'b0;
          end
        end else if (r_rx_active) begin
          // bytes past the length limit are dropped; flag only the first
          if (w_over) begin
            if (!r_ovf_seen) begin
              w_err      = 1'b1;
              w_ovf_seen = 1'b1;
            end
          end else begin
            w_data_valid = 1'b1;
            w_data       = r_data;
            w_len        = w_len_sat;
            w_sop        = r_sop_pend;
            w_sop_pend   = 1'b0;
          end
        end else begin
          w_err = 1'b1;
        end
      end
      TURN_OUT: begin
        if (r_rx_active) begin
          w_active   = 1'b0;
          w_eop      = 1'b1;
          w_sop_pend = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // stage 2: registered outputs and packet bookkeeping
  always_ff @(posedge ULPICLK or posedge ULPIRST) begin
    if (ULPIRST) begin
      r_cmd_valid  <= 1'b0;
      r_data_valid <= 1'b0;
      r_ulpi_data  <= 8'h00;
      r_rx_active  <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_err        <= 1'b0;
      r_len        <= '0;
      r_link_owns  <= 1'b1;
      r_sop_pend   <= 1'b0;
      r_ovf_seen   <= 1'b0;
    end else begin
      r_cmd_valid  <= w_cmd_valid;
      r_data_valid <= w_data_valid;
      r_ulpi_data  <= w_data;
      r_rx_active  <= w_active;
      r_sop        <= w_sop;
      r_eop        <= w_eop;
      r_err        <= w_err;
      r_len        <= w_len;
      r_link_owns  <= (w_state_nxt == IDLE);
      r_sop_pend   <= w_sop_pend;
      r_ovf_seen   <= w_ovf_seen;
    end
  end

  assign RXD_CMD_VALID  = r_cmd_valid;
  assign RXD_DATA_VALID = r_data_valid;
  assign ULPI_DATA      = r_ulpi_data;
  assign RX_ACTIVE      = r_rx_active;
  assign RX_SOP         = r_sop;
  assign RX_EOP         = r_eop;
  assign RX_ERR         = r_err;
  assign RX_LEN         = r_len;
  assign LINK_OWNS_BUS  = r_link_owns;

`ifdef SC_ULPI_RXIF_STAT_EN
  sc_ulpi_rxstat u_rxstat (
    .i_clk     (ULPICLK),
    .i_rst     (ULPIRST),
    .i_pkt_evt (r_eop),
    .i_err_evt (r_err),
    .o_pkt_cnt (STAT_PKT_CNT),
    .o_err_cnt (STAT_ERR_CNT)
  );
`else
  assign STAT_PKT_CNT = 16'h0000;
  assign STAT_ERR_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_sc_ulpi_rxif.sv
// Bench for sc_ulpi_rxif (MAX_PKT_LEN = 4). Expected strobe cycles are
// queued as stimulus is driven and matched by a negedge monitor.
module tb_sc_ulpi_rxif;

  logic        ULPICLK = 1'b0;
  logic        ULPIRST = 1'b1;
  logic        ULPI_DIR = 1'b0;
  logic        ULPI_NXT = 1'b0;
  logic [7:0]  ULPI_DATA_I = 8'h00;
  logic        RXD_CMD_VALID, RXD_DATA_VALID;
  logic [7:0]  ULPI_DATA;
  logic        RX_ACTIVE, RX_SOP, RX_EOP, RX_ERR;
  logic [10:0] RX_LEN;
  logic [15:0] STAT_PKT_CNT, STAT_ERR_CNT;
  logic        LINK_OWNS_BUS;

  sc_ulpi_rxif #(.MAX_PKT_LEN(4)) dut (
    .ULPICLK(ULPICLK), .ULPIRST(ULPIRST), .ULPI_DIR(ULPI_DIR), .ULPI_NXT(ULPI_NXT),
    .ULPI_DATA_I(ULPI_DATA_I), .RXD_CMD_VALID(RXD_CMD_VALID), .RXD_DATA_VALID(RXD_DATA_VALID),
    .ULPI_DATA(ULPI_DATA), .RX_ACTIVE(RX_ACTIVE), .RX_SOP(RX_SOP), .RX_EOP(RX_EOP),
    .RX_ERR(RX_ERR), .RX_LEN(RX_LEN), .STAT_PKT_CNT(STAT_PKT_CNT),
    .STAT_ERR_CNT(STAT_ERR_CNT), .LINK_OWNS_BUS(LINK_OWNS_BUS)
  );

  typedef struct {
    int          cyc;
    logic        cmd_v;
    logic        data_v;
    logic        sop;
    logic        eop;
    logic        err;
    logic [7:0]  data;
    logic [10:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_chk = 0, n_pass = 0, cyc = 0;
  int link_hi_cnt = 0, act_seen = 0, eop_seen = 0;
  int exp_pkts = 0, exp_errs = 0;

  always #5 ULPICLK = ~ULPICLK;
  always @(posedge ULPICLK) cyc++;

  // queue one expected strobe cycle, two cycles after the byte driven now
  function automatic void sb_push(input logic cmd_v, input logic data_v, input logic sop,
                                  input logic eop, input logic err, input logic [7:0] d,
                                  input logic [10:0] len);
    exp_t e;
    e.cyc = cyc + 2; e.cmd_v = cmd_v; e.data_v = data_v; e.sop = sop;
    e.eop = eop; e.err = err; e.data = d; e.len = len;
    exp_q.push_back(e);
    if (eop) exp_pkts++;
    if (err) exp_errs++;
  endfunction

  task automatic step(input logic d, input logic n, input logic [7:0] x);
    ULPI_DIR = d; ULPI_NXT = n; ULPI_DATA_I = x;
    @(posedge ULPICLK); #1;
  endtask

  // scoreboard monitor
  always @(negedge ULPICLK) begin
    if (ULPIRST !== 1'b1) begin
      if (LINK_OWNS_BUS) link_hi_cnt++;
      if (RX_ACTIVE) act_seen++;
      if (RX_EOP) eop_seen++;
      if (RXD_CMD_VALID || RXD_DATA_VALID || RX_SOP || RX_EOP || RX_ERR) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: cyc %0d got cmd=%b dat=%b sop=%b eop=%b err=%b byte=%h len=%0d, required no strobe",
                   cyc, RXD_CMD_VALID, RXD_DATA_VALID, RX_SOP, RX_EOP, RX_ERR, ULPI_DATA, RX_LEN);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc == cyc &&
              {RXD_CMD_VALID, RXD_DATA_VALID, RX_SOP, RX_EOP, RX_ERR} ===
              {mon_e.cmd_v, mon_e.data_v, mon_e.sop, mon_e.eop, mon_e.err} &&
              (!(mon_e.cmd_v || mon_e.data_v) || ULPI_DATA === mon_e.data) &&
              (!(mon_e.data_v || mon_e.eop) || RX_LEN === mon_e.len))
            n_pass++;
          else
            $display("FAIL sb_event: cyc %0d got cmd=%b dat=%b sop=%b eop=%b err=%b byte=%h len=%0d, required cyc %0d cmd=%b dat=%b sop=%b eop=%b err=%b byte=%h len=%0d",
                     cyc, RXD_CMD_VALID, RXD_DATA_VALID, RX_SOP, RX_EOP, RX_ERR, ULPI_DATA, RX_LEN,
                     mon_e.cyc, mon_e.cmd_v, mon_e.data_v, mon_e.sop, mon_e.eop, mon_e.err, mon_e.data, mon_e.len);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        n_chk++;
        mon_e = exp_q.pop_front();
        $display("FAIL sb_missing: cyc %0d got no strobe, required cyc %0d cmd=%b dat=%b sop=%b eop=%b err=%b byte=%h",
                 cyc, mon_e.cyc, mon_e.cmd_v, mon_e.data_v, mon_e.sop, mon_e.eop, mon_e.err, mon_e.data);
      end
    end
  end

  task automatic test_reset();
    ULPIRST = 1'b1;
    repeat (3) @(posedge ULPICLK);
    #2;
    n_chk++;
    if ({RXD_CMD_VALID, RXD_DATA_VALID, RX_ACTIVE, RX_SOP, RX_EOP, RX_ERR} !== 6'b0)
      $display("FAIL reset_strobes: got %b, required 000000",
               {RXD_CMD_VALID, RXD_DATA_VALID, RX_ACTIVE, RX_SOP, RX_EOP, RX_ERR});
    else n_pass++;
    n_chk++;
    if ({ULPI_DATA, RX_LEN} !== 19'h0)
      $display("FAIL reset_data_len: got data=%h len=%0d, required 0", ULPI_DATA, RX_LEN);
    else n_pass++;
    n_chk++;
    if ({STAT_PKT_CNT, STAT_ERR_CNT} !== 32'h0)
      $display("FAIL reset_stat: got %h/%h, required 0", STAT_PKT_CNT, STAT_ERR_CNT);
    else n_pass++;
    n_chk++;
    if (LINK_OWNS_BUS !== 1'b1) $display("FAIL reset_link: got %b, required 1", LINK_OWNS_BUS);
    else n_pass++;
    @(posedge ULPICLK); #1;
    ULPIRST = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_end(input string name);
    int want_pkts, want_errs;
`ifdef SC_ULPI_RXIF_STAT_EN
    want_pkts = exp_pkts; want_errs = exp_errs;
`else
    want_pkts = 0; want_errs = 0;
`endif
    n_chk++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
    else n_pass++;
    n_chk++;
    if (STAT_PKT_CNT !== 16'(want_pkts) || STAT_ERR_CNT !== 16'(want_errs))
      $display("FAIL %s_stat: got pkt=%0d err=%0d, required pkt=%0d err=%0d",
               name, STAT_PKT_CNT, STAT_ERR_CNT, want_pkts, want_errs);
    else n_pass++;
    n_chk++;
    if (LINK_OWNS_BUS !== 1'b1 || RX_ACTIVE !== 1'b0)
      $display("FAIL %s_idle: got link=%b active=%b, required link=1 active=0", name, LINK_OWNS_BUS, RX_ACTIVE);
    else n_pass++;
  endtask

  task automatic test_rx_cmd();
    act_seen = 0;
    step(1'b1, 1'b0, 8'hFF);
    sb_push(1, 0, 0, 0, 0, 8'h4D, 11'd0);
    step(1'b1, 1'b0, 8'h4D);
    step(1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (act_seen != 0) $display("FAIL rx_cmd_active: got %0d active cycles, required 0", act_seen);
    else n_pass++;
    check_end("rx_cmd");
  endtask

  task automatic test_drop_inactive();
    step(1'b1, 1'b0, 8'hFF);
    sb_push(0, 0, 0, 0, 1, 8'h00, 11'd0);
    step(1'b1, 1'b1, 8'h55);
    repeat (5) step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (ULPI_DATA !== 8'h4D) $display("FAIL drop_hold: got ULPI_DATA=%h, required 4d", ULPI_DATA);
    else n_pass++;
    check_end("drop");
  endtask

  task automatic test_packet();
    logic [7:0] bytes [3];
    bytes[0] = 8'hC3; bytes[1] = 8'h01; bytes[2] = 8'h02;
    step(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      sb_push(0, 1, (i == 0), 0, 0, bytes[i], 11'(i + 1));
      step(1'b1, 1'b1, bytes[i]);
    end
    sb_push(0, 0, 0, 1, 0, 8'h00, 11'd3);
    step(1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (RX_LEN !== 11'd3) $display("FAIL pkt_len_hold: got %0d, required 3", RX_LEN);
    else n_pass++;
    check_end("pkt");
  endtask

  task automatic test_rx_error();
    step(1'b1, 1'b0, 8'hFF);
    sb_push(1, 0, 0, 0, 0, 8'h10, 11'd0);
    step(1'b1, 1'b0, 8'h10);
    sb_push(0, 1, 1, 0, 0, 8'hAA, 11'd1);
    step(1'b1, 1'b1, 8'hAA);
    sb_push(1, 0, 0, 0, 1, 8'h30, 11'd0);
    step(1'b1, 1'b0, 8'h30);
    sb_push(0, 1, 0, 0, 0, 8'hBB, 11'd2);
    step(1'b1, 1'b1, 8'hBB);
    sb_push(1, 0, 0, 1, 0, 8'h0C, 11'd2);
    step(1'b1, 1'b0, 8'h0C);
    repeat (5) step(1'b0, 1'b0, 8'h00);
    check_end("rx_err");
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    step(1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      b = 8'h10 + 8'(i);
      if (i < 4)       sb_push(0, 1, (i == 0), 0, 0, b, 11'(i + 1));
      else if (i == 4) sb_push(0, 0, 0, 0, 1, 8'h00, 11'd0);
      step(1'b1, 1'b1, b);
    end
    sb_push(0, 0, 0, 1, 0, 8'h00, 11'd4);
    step(1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (RX_LEN !== 11'd4) $display("FAIL ovf_len: got %0d, required 4", RX_LEN);
    else n_pass++;
    check_end("ovf");
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 8'hFF);
    sb_push(1, 0, 0, 0, 0, 8'h41, 11'd0);
    step(1'b1, 1'b0, 8'h41);
    link_hi_cnt = 0;
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h77);
    sb_push(1, 0, 0, 0, 0, 8'h42, 11'd0);
    step(1'b1, 1'b0, 8'h42);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (link_hi_cnt != 0) $display("FAIL b2b_link: got %0d owned cycles, required 0", link_hi_cnt);
    else n_pass++;
    repeat (4) step(1'b0, 1'b0, 8'h00);
    check_end("b2b");
  endtask

  task automatic test_reset_mid();
    int eop_before;
    step(1'b1, 1'b1, 8'hFF);
    sb_push(0, 1, 1, 0, 0, 8'hA1, 11'd1);
    step(1'b1, 1'b1, 8'hA1);
    sb_push(0, 1, 0, 0, 0, 8'hA2, 11'd2);
    step(1'b1, 1'b1, 8'hA2);
    step(1'b1, 1'b0, 8'h1C);
    @(negedge ULPICLK); #1;
    eop_before = eop_seen;
    ULPIRST = 1'b1;
    ULPI_DIR = 1'b0; ULPI_NXT = 1'b0; ULPI_DATA_I = 8'h00;
    #1;
    n_chk++;
    if ({RXD_CMD_VALID, RXD_DATA_VALID, RX_ACTIVE, RX_SOP, RX_EOP, RX_ERR, ULPI_DATA, RX_LEN} !== 25'h0)
      $display("FAIL rstmid_outputs: got flags=%b data=%h len=%0d, required all 0",
               {RXD_CMD_VALID, RXD_DATA_VALID, RX_ACTIVE, RX_SOP, RX_EOP, RX_ERR}, ULPI_DATA, RX_LEN);
    else n_pass++;
    n_chk++;
    if ({STAT_PKT_CNT, STAT_ERR_CNT} !== 32'h0 || LINK_OWNS_BUS !== 1'b1)
      $display("FAIL rstmid_stat_link: got %h/%h link=%b, required 0/0 link=1",
               STAT_PKT_CNT, STAT_ERR_CNT, LINK_OWNS_BUS);
    else n_pass++;
    exp_pkts = 0; exp_errs = 0;
    repeat (2) @(posedge ULPICLK);
    #1;
    ULPIRST = 1'b0;
    repeat (6) step(1'b0, 1'b0, 8'h00);
    n_chk++;
    if (eop_seen != eop_before) $display("FAIL rstmid_eop: got %0d eop after reset, required 0", eop_seen - eop_before);
    else n_pass++;
    check_end("rstmid");
  endtask

  initial begin
    test_reset();
    test_rx_cmd();
    test_drop_inactive();
    test_packet();
    test_rx_error();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sc_ulpi_rxif.md
SC_ULPI_RXIF -- requirements
Module: sc_ulpi_rxif

Interface
REQ-001 SHALL have parameter MAX_PKT_LEN, default 1027, giving the maximum accepted data bytes per packet (1024 payload + PID + CRC16).
REQ-002 SHALL have port ULPICLK, input, 1, the 60 MHz ULPI clock; the block's only clock.
REQ-003 SHALL have port ULPIRST, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port ULPI_DIR, input, 1, raw bus-direction pad; high means the PHY drives the bus.
REQ-005 SHALL have port ULPI_NXT, input, 1, raw PHY next pad.
REQ-006 SHALL have port ULPI_DATA_I, input, 8, raw ULPI data pads.
REQ-007 SHALL have port RXD_CMD_VALID, output, 1, one-cycle strobe: ULPI_DATA carries an RX CMD byte.
REQ-008 SHALL have port RXD_DATA_VALID, output, 1, one-cycle strobe: ULPI_DATA carries a received USB data byte.
REQ-009 SHALL have port ULPI_DATA, output, 8, byte qualified by the two strobes above; holds its last value otherwise.
REQ-010 SHALL have ports RX_ACTIVE, RX_SOP, RX_EOP and RX_ERR, each output, 1: packet in progress, first data byte, end strobe and error strobe.
REQ-011 SHALL have port RX_LEN, output, 11, data-byte count of the current or last packet.
REQ-012 SHALL have ports STAT_PKT_CNT and STAT_ERR_CNT, each output, 16: packet and error counters.
REQ-013 SHALL have port LINK_OWNS_BUS, output, 1, high only in state IDLE; gates the transmit driver.

Function
REQ-014 SHALL register DIR, NXT and DATA once at the pads (stage 1), and SHALL register all outputs (stage 2); pad-to-output latency is exactly 2 cycles.
REQ-015 SHALL implement the FSM IDLE, TURN_IN, RECV, TURN_OUT, using the stage-1 signals.
- IDLE -> TURN_IN when DIR = 1.
- TURN_IN -> RECV when DIR = 1; TURN_IN -> TURN_OUT when DIR = 0.
- RECV stays in RECV while DIR = 1; RECV -> TURN_OUT when DIR = 0.
- TURN_OUT -> TURN_IN when DIR = 1; TURN_OUT -> IDLE otherwise.
REQ-016 SHALL ignore DATA in TURN_IN and TURN_OUT, and SHALL issue no strobe in those states.
REQ-017 In TURN_IN with NXT = 1, SHALL set RX_ACTIVE on the next cycle (RxActive turnaround) and SHALL clear RX_LEN to 0.
REQ-018 In RECV, each cycle SHALL strobe exactly one of the following:
- NXT = 0: RXD_CMD_VALID.
- NXT = 1 and RX_ACTIVE = 1: RXD_DATA_VALID.
REQ-019 In RECV with NXT = 1 and RX_ACTIVE = 0, SHALL drop the byte and strobe RX_ERR.
REQ-020 An RX CMD whose rxEvent field is RxActive SHALL set RX_ACTIVE if it is clear, and SHALL clear RX_LEN.
REQ-021 RX_SOP SHALL coincide with the first RXD_DATA_VALID after RX_ACTIVE rises.
REQ-022 RX_LEN SHALL increment on every RXD_DATA_VALID and SHALL saturate at 2047.
REQ-023 Each RXD_DATA_VALID SHALL be accompanied by the updated RX_LEN value.
REQ-024 A data byte that would make RX_LEN exceed MAX_PKT_LEN SHALL be discarded, and SHALL strobe RX_ERR once per packet.
REQ-025 While RX_ACTIVE = 1, an RX CMD with rxEvent = RxError SHALL strobe RX_ERR and SHALL still pass through as RXD_CMD_VALID.
REQ-026 RX_ACTIVE SHALL fall, with a one-cycle RX_EOP, on whichever occurs first:
- an RX CMD whose rxEvent is neither RxActive nor RxError;
- a RECV -> TURN_OUT transition.
REQ-027 If a falling-RX_ACTIVE condition and an RX_ERR condition occur in the same cycle, RX_EOP and RX_ERR SHALL both assert.
REQ-028 A DIR rise during TURN_OUT SHALL behave exactly as a rise from IDLE.
REQ-029 RX_LEN SHALL hold its value after RX_EOP until the next packet starts.

Reset
REQ-030 While ULPIRST = 1, every output and register SHALL be 0 and the FSM SHALL be in IDLE; LINK_OWNS_BUS SHALL be 1.
REQ-031 Reset asserted mid-packet SHALL abandon the packet with no RX_EOP and no RX_ERR.
REQ-032 After ULPIRST falls, the first DIR = 1 sample SHALL be treated as a turnaround.

Configuration
REQ-033 SHALL use macro SC_ULPI_RXIF_STAT_EN.
- Defined: STAT_PKT_CNT increments on each RX_EOP; STAT_ERR_CNT increments on each RX_ERR.
- Defined: both counters saturate at 16'hFFFF and clear only on reset.
- Undefined: both ports are constant 0, no counter logic is built, and all other behaviour is unchanged.

Structure
REQ-034 The FSM enum rxIfState_e and the rxEvent encoding constants (RxActive = 2'b01, RxError = 2'b11, HostDisconnect = 2'b10) SHALL reside in sc_ulpi_pkg.
REQ-035 RX CMD decoding SHALL reuse rxCmd_s from sc_ulpi_pkg.
REQ-036 The counters SHALL be the sub-module sc_ulpi_rxstat, instantiated only under SC_ULPI_RXIF_STAT_EN.
REQ-037 The outputs RXD_CMD_VALID, RXD_DATA_VALID and ULPI_DATA SHALL connect directly to the equally named inputs of the downstream receive-command consumer.

Verification
REQ-038 Bench SHALL cover a lone RX CMD.
- Stimulus: DIR rises, then DIR = 1 with NXT = 0 and DATA = 8'h4D, then DIR falls.
- Response: exactly one RXD_CMD_VALID with ULPI_DATA = 8'h4D, 2 cycles after the byte cycle, and no RX_ACTIVE.
REQ-039 Bench SHALL cover a packet started by an RxActive turnaround.
- Stimulus: DIR and NXT both 1 in the turnaround cycle, then data bytes C3, 01, 02 with NXT = 1, then DIR falls.
- Response: RX_SOP on C3; three RXD_DATA_VALID strobes; RX_EOP with RX_LEN = 3; STAT_PKT_CNT = 1 when the macro is defined.
REQ-040 Bench SHALL cover an RxError RX CMD.
- Stimulus: an RX CMD with rxEvent = 2'b11 inside an active packet.
- Response: RX_ERR = 1 for one cycle, and RXD_CMD_VALID passes that byte.
REQ-041 Bench SHALL cover the overflow boundary.
- Stimulus: MAX_PKT_LEN = 4 and 6 data bytes.
- Response: 4 RXD_DATA_VALID strobes, one RX_ERR, and RX_LEN = 4 at RX_EOP.
REQ-042 Bench SHALL cover a back-to-back direction change.
- Stimulus: DIR falls, then rises again in the TURN_OUT cycle.
- Response: LINK_OWNS_BUS stays 0 and the next byte is discarded as a turnaround.
REQ-043 Bench SHALL cover reset mid-packet.
- Stimulus: ULPIRST pulses after 2 data bytes.
- Response: all outputs are 0 immediately and no RX_EOP appears afterwards.
